// File: rtl/stage_seq_pkg.sv
// Shared definitions for the stage sequencer: FSM state codes and default stage count.
package stage_seq_pkg;

  typedef logic [1:0] stage_seq_state_t;

  localparam stage_seq_state_t STAGE_SEQ_IDLE  = 2'd0;
  localparam stage_seq_state_t STAGE_SEQ_CLEAR = 2'd1;
  localparam stage_seq_state_t STAGE_SEQ_RUN   = 2'd2;
  localparam stage_seq_state_t STAGE_SEQ_HALT  = 2'd3;

  localparam int STAGE_SEQ_DEFAULT_STAGES = 5;

endpackage

// File: rtl/stage_seq_stall_watchdog.sv
// Consecutive-stall counter with a sticky timeout flag; built only when
// STAGE_SEQ_STALL_WATCHDOG_EN is defined.
module stall_watchdog #(
  parameter int STALL_LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic stall_cycle,
  output logic hit,
  output logic timeout
);

  localparam int CNT_W = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  // hit fires on the STALL_LIMIT-th consecutive stall cycle
  always_comb begin
    hit       = stall_cycle && (cnt_q == CNT_W'(STALL_LIMIT - 1));
    cnt_d     = stall_cycle ? cnt_q + CNT_W'(1) : '0;
    timeout_d = timeout_q | hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;

endmodule

// File: rtl/stage_sequencer.sv
// One-hot stage token sequencer with stall, flush, stop-at-boundary and retire count.
// Optional stall watchdog: define STAGE_SEQ_STALL_WATCHDOG_EN.
module stage_sequencer
  import stage_seq_pkg::*;
#(
  parameter int NUM_STAGES  = STAGE_SEQ_DEFAULT_STAGES,
  parameter int COUNT_W     = 32,
  parameter int STALL_LIMIT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [NUM_STAGES-1:0] stall,
  input  logic                  flush,
  output logic [NUM_STAGES-1:0] stage_wren,
  output logic                  stage_clear,
  output logic                  commit,
  output logic [NUM_STAGES-1:0] stage_onehot,
  output logic                  busy,
  output logic [COUNT_W-1:0]    instr_count,
  output logic                  stall_timeout
);

  localparam logic [NUM_STAGES-1:0] TOKEN_FIRST = {{(NUM_STAGES-1){1'b0}}, 1'b1};

  if (NUM_STAGES < 2 || STALL_LIMIT < 1) begin : g_bad_cfg
    $error("stage_sequencer: NUM_STAGES must be >= 2 and STALL_LIMIT >= 1");
  end

  stage_seq_state_t      state_q, state_d;
  logic [NUM_STAGES-1:0] token_q, token_d;
  logic [COUNT_W-1:0]    count_q, count_d;
  logic [NUM_STAGES-1:0] stage_wren_s;
  logic                  commit_s;
  logic                  stall_cur_s;
  logic                  wd_hit_s;

  // only the stall bit of the stage holding the token matters
  assign stall_cur_s = |(stall & token_q);

`ifdef STAGE_SEQ_STALL_WATCHDOG_EN
  logic stall_cycle_s;
  assign stall_cycle_s = (state_q == STAGE_SEQ_RUN) && !flush && stall_cur_s;

  stall_watchdog #(
    .STALL_LIMIT(STALL_LIMIT)
  ) u_stall_watchdog (
    .clk        (clk),
    .reset      (reset),
    .stall_cycle(stall_cycle_s),
    .hit        (wd_hit_s),
    .timeout    (stall_timeout)
  );
`else
  assign wd_hit_s      = 1'b0;
  assign stall_timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    token_d      = token_q;
    count_d      = count_q;
    stage_wren_s = '0;
    commit_s     = 1'b0;
    case (state_q)
      STAGE_SEQ_IDLE: begin
        token_d = TOKEN_FIRST;
        if (run) state_d = STAGE_SEQ_CLEAR;
        else     state_d = STAGE_SEQ_IDLE;
      end
      STAGE_SEQ_CLEAR: begin
        token_d = TOKEN_FIRST;
        state_d = STAGE_SEQ_RUN;
      end
      STAGE_SEQ_RUN: begin
        // flush outranks both stall and advance
        if (flush) begin
          token_d = TOKEN_FIRST;
          state_d = STAGE_SEQ_CLEAR;
        end else if (stall_cur_s) begin
          if (wd_hit_s) state_d = STAGE_SEQ_HALT;
          else          state_d = STAGE_SEQ_RUN;
        end else begin
          stage_wren_s = token_q;
          token_d      = {token_q[NUM_STAGES-2:0], token_q[NUM_STAGES-1]};
          if (token_q[NUM_STAGES-1]) begin
            commit_s = 1'b1;
            count_d  = count_q + COUNT_W'(1);
            if (!run) state_d = STAGE_SEQ_IDLE;
            else      state_d = STAGE_SEQ_RUN;
          end else begin
            state_d = STAGE_SEQ_RUN;
          end
        end
      end
      STAGE_SEQ_HALT: begin
        state_d = STAGE_SEQ_HALT;
      end
      default: begin
        state_d = STAGE_SEQ_IDLE;
        token_d = TOKEN_FIRST;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= STAGE_SEQ_IDLE;
      token_q <= TOKEN_FIRST;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      token_q <= token_d;
      count_q <= count_d;
    end
  end

  assign stage_wren   = stage_wren_s;
  assign commit       = commit_s;
  assign stage_clear  = (state_q == STAGE_SEQ_CLEAR);
  assign busy         = (state_q == STAGE_SEQ_CLEAR) || (state_q == STAGE_SEQ_RUN);
  assign stage_onehot = token_q;
  assign instr_count  = count_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Randomized + directed bench for stage_sequencer against a behavioural model.
// Honours STAGE_SEQ_STALL_WATCHDOG_EN the same way the design does.
module tb_stage_sequencer;

  localparam int N   = 5;
  localparam int CW  = 3;
  localparam int LIM = 4;
`ifdef STAGE_SEQ_STALL_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          run = 1'b0;
  logic [N-1:0]  stall = '0;
  logic          flush = 1'b0;
  logic [N-1:0]  stage_wren;
  logic          stage_clear;
  logic          commit;
  logic [N-1:0]  stage_onehot;
  logic          busy;
  logic [CW-1:0] instr_count;
  logic          stall_timeout;

  stage_sequencer #(.NUM_STAGES(N), .COUNT_W(CW), .STALL_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset), .run(run), .stall(stall), .flush(flush),
    .stage_wren(stage_wren), .stage_clear(stage_clear), .commit(commit),
    .stage_onehot(stage_onehot), .busy(busy), .instr_count(instr_count),
    .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model: phase 0 idle, 1 clear, 2 executing, 3 halted
  int m_phase, m_pos, m_retired, m_stalls;
  bit m_timeout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_pos = 0; m_retired = 0; m_stalls = 0; m_timeout = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_onehot"}, 32'(stage_onehot), 32'd1);
    check({tag, "_wren"}, 32'(stage_wren), 32'd0);
    check({tag, "_clear"}, 32'(stage_clear), 32'd0);
    check({tag, "_commit"}, 32'(commit), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_count"}, 32'(instr_count), 32'd0);
    check({tag, "_timeout"}, 32'(stall_timeout), 32'd0);
  endtask

  task automatic check_outputs();
    int advancing;
    advancing = (m_phase == 2) && !flush && !stall[m_pos];
    check("wren", 32'(stage_wren), advancing ? (32'd1 << m_pos) : 32'd0);
    check("commit", 32'(commit), (advancing && m_pos == N - 1) ? 32'd1 : 32'd0);
    check("clear", 32'(stage_clear), (m_phase == 1) ? 32'd1 : 32'd0);
    check("busy", 32'(busy), (m_phase == 1 || m_phase == 2) ? 32'd1 : 32'd0);
    check("onehot", 32'(stage_onehot), 32'd1 << m_pos);
    check("count", 32'(instr_count), 32'(m_retired));
    check("timeout", 32'(stall_timeout), 32'(m_timeout));
  endtask

  task automatic model_step();
    case (m_phase)
      0: begin m_pos = 0; if (run) m_phase = 1; end
      1: begin m_pos = 0; m_phase = 2; end
      2: begin
        if (flush) begin
          m_phase = 1; m_pos = 0; m_stalls = 0;
        end else if (stall[m_pos]) begin
          m_stalls++;
          if (WD && m_stalls == LIM) begin m_phase = 3; m_timeout = 1'b1; end
        end else begin
          m_stalls = 0;
          if (m_pos == N - 1) begin
            m_pos = 0;
            m_retired = (m_retired + 1) % (1 << CW);
            if (!run) m_phase = 0;
          end else begin
            m_pos++;
          end
        end
      end
      default: ;
    endcase
  endtask

  // called at a negedge; drives, checks mid-cycle, lets the posedge pass
  task automatic cycle(input logic r, input logic [N-1:0] st, input logic fl);
    run = r; stall = st; flush = fl;
    #1;
    check_outputs();
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_reset_values("rst");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // plain run: clear at cycle 1, wren from cycle 2, two commits by cycle 12
    for (int i = 0; i < 12; i++) cycle(1'b1, '0, 1'b0);
    check("plan_count2", 32'(instr_count), 32'd2);

    // stall stage 3 for three cycles
    for (int k = 0; k < 20 && m_pos != 3; k++) cycle(1'b1, '0, 1'b0);
    check("reach_s3", 32'(stage_onehot), 32'd8);
    for (int i = 0; i < 3; i++) cycle(1'b1, 5'b01000, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b1, '0, 1'b0);

    // flush at stage 2 together with stall[2]
    for (int k = 0; k < 20 && m_pos != 2; k++) cycle(1'b1, '0, 1'b0);
    check("reach_s2", 32'(stage_onehot), 32'd4);
    cycle(1'b1, 5'b00100, 1'b1);
    check("flush_clear", 32'(stage_clear), 32'd1);
    for (int i = 0; i < 4; i++) cycle(1'b1, '0, 1'b0);

    // drop run at stage 1: instruction completes, then idle
    for (int k = 0; k < 20 && m_pos != 1; k++) cycle(1'b1, '0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b0);
    check("stop_idle_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b1, '0, 1'b0);

    // counter wrap: nine instructions from reset
    do_reset();
    for (int i = 0; i < 2 + 9 * N; i++) cycle(1'b1, '0, 1'b0);
    check("wrap_count", 32'(instr_count), 32'd1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 9) != 0),
            ($urandom_range(0, 4) == 0) ? N'($urandom) : N'(0),
            ($urandom_range(0, 19) == 0));
      if (m_phase == 3) do_reset();
    end

    // watchdog: stall[1] held
    do_reset();
    for (int k = 0; k < 20 && m_pos != 1; k++) cycle(1'b1, '0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 5'b00010, 1'b0);
    check("wd_timeout", 32'(stall_timeout), WD ? 32'd1 : 32'd0);
    check("wd_busy", 32'(busy), WD ? 32'd0 : 32'd1);
    cycle(1'b1, '0, 1'b1);

    // asynchronous reset mid-stage-3
    do_reset();
    for (int k = 0; k < 20 && m_pos != 3; k++) cycle(1'b1, '0, 1'b0);
    run = 1'b1; stall = '0; flush = 1'b0;
    #1;
    check("pre_async_wren", 32'(stage_wren), 32'd8);
    reset = 1'b1;
    #1;
    model_reset();
    check_reset_values("async");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1'b1, '0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
